conv_tile_scheduler: RTL and testbench

- Top-level sequencer for one convolution layer on the 32x32x3 systolic array.
- Loads weights once, then for every output tile runs three steps in order: triggers the IFM address generator (window fetch), starts the array compute, and issues writeback of the tile.
- Writeback of tile n overlaps the IFM fetch of tile n+1. A single output buffer forces compute of tile n+1 to wait for writeback of tile n to finish.
- Tracks tile index and the OFM base address for the writeback engine.

---
 rtl/conv_ctrl_pkg.sv | 18 +
 rtl/pulse_edge_det.sv | 16 +
 rtl/conv_tile_scheduler.sv | 107 ++++++++++
 tb/tb_conv_tile_scheduler.sv | 137 +++++++++++++
 4 files changed

// File: rtl/conv_ctrl_pkg.sv
// conv_ctrl_pkg: shared state encoding and tiling defaults for the conv layer controllers
package conv_ctrl_pkg;
  localparam int OFM_SIZE_DEF = 32;
  localparam int TILE_W_DEF = 16;
  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_WGT_REQ = 4'd1;
  localparam logic [3:0] S_WGT_WAIT = 4'd2;
  localparam logic [3:0] S_FETCH_REQ = 4'd3;
  localparam logic [3:0] S_FETCH_WAIT = 4'd4;
  localparam logic [3:0] S_COMP_HOLD = 4'd5;
  localparam logic [3:0] S_COMP_REQ = 4'd6;
  localparam logic [3:0] S_COMP_WAIT = 4'd7;
  localparam logic [3:0] S_DRAIN = 4'd8;
  localparam logic [3:0] S_DONE = 4'd9;
  function automatic int num_tiles(input int ofm_size, input int tile_w);
    return ofm_size * ofm_size / tile_w;
  endfunction
endpackage

// File: rtl/pulse_edge_det.sv
// pulse_edge_det: armed falling-edge detector; fall only counts after sig was seen high while enabled
module pulse_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic sig,
  output logic fall
);
  logic armed;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) armed <= 1'b0;
    else if (clr) armed <= 1'b0;
    else if (en && sig) armed <= 1'b1;
  assign fall = en && armed && !sig;
endmodule

// File: rtl/conv_tile_scheduler.sv
// conv_tile_scheduler: per-layer sequencer; weight load, then fetch/compute/writeback per output tile
module conv_tile_scheduler
  import conv_ctrl_pkg::*;
#(
  parameter int OFM_SIZE = OFM_SIZE_DEF,
  parameter int TILE_W = TILE_W_DEF,
  parameter int ADDR_WIDTH = 19,
  parameter int TILE_CNT_W = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  wgt_load,
  input  logic                  wgt_done,
  output logic                  ifm_load,
  input  logic                  ifm_addr_valid,
  output logic                  sa_start,
  input  logic                  sa_done,
  output logic                  wb_start,
  input  logic                  wb_done,
  output logic [ADDR_WIDTH-1:0] ofm_base_addr,
  output logic [TILE_CNT_W-1:0] tile_idx
);
  localparam int NT = num_tiles(OFM_SIZE, TILE_W);
  localparam logic [TILE_CNT_W-1:0] LAST = TILE_CNT_W'(NT - 1);
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(TILE_W);
  logic [3:0] state;
  logic wb_pending, fetch_done, buf_free;
  logic [ADDR_WIDTH-1:0] next_base;
  // a writeback finishing this very cycle frees the buffer without an extra stall
  assign buf_free = !wb_pending || wb_done;
  pulse_edge_det u_fetch_det (
    .clk(clk),
    .rst_n(rst_n),
    .clr(state == S_FETCH_REQ),
    .en(state == S_FETCH_WAIT),
    .sig(ifm_addr_valid),
    .fall(fetch_done)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      wgt_load <= 1'b0;
      ifm_load <= 1'b0;
      sa_start <= 1'b0;
      wb_start <= 1'b0;
      wb_pending <= 1'b0;
      ofm_base_addr <= '0;
      next_base <= '0;
      tile_idx <= '0;
    end else begin
      wgt_load <= 1'b0;
      ifm_load <= 1'b0;
      sa_start <= 1'b0;
      wb_start <= 1'b0;
      done <= 1'b0;
      if (wb_done) wb_pending <= 1'b0;
      case (state)
        S_IDLE:
          if (start) begin
            state <= S_WGT_REQ;
            busy <= 1'b1;
            tile_idx <= '0;
            next_base <= '0;
            wgt_load <= 1'b1;
          end
        S_WGT_REQ: state <= S_WGT_WAIT;
        S_WGT_WAIT:
          if (wgt_done) begin
            state <= S_FETCH_REQ;
            ifm_load <= 1'b1;
          end
        S_FETCH_REQ: state <= S_FETCH_WAIT;
        S_FETCH_WAIT: if (fetch_done) state <= S_COMP_HOLD;
        S_COMP_HOLD:
          if (buf_free) begin
            state <= S_COMP_REQ;
            sa_start <= 1'b1;
          end
        S_COMP_REQ: state <= S_COMP_WAIT;
        S_COMP_WAIT:
          if (sa_done) begin
            wb_start <= 1'b1;
            wb_pending <= 1'b1;
            ofm_base_addr <= next_base;
            next_base <= next_base + STEP;
            if (tile_idx == LAST) state <= S_DRAIN;
            else begin
              tile_idx <= tile_idx + 1'b1;
              state <= S_FETCH_REQ;
              ifm_load <= 1'b1;
            end
          end
        S_DRAIN: if (buf_free) state <= S_DONE;
        S_DONE: begin
          done <= 1'b1;
          busy <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_conv_tile_scheduler.sv
// tb_conv_tile_scheduler: directed runs with latency-programmable responders and timing checks
module tb_conv_tile_scheduler;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic wgt_done = 1'b0, ifm_addr_valid = 1'b0, sa_done = 1'b0, wb_done = 1'b0;
  logic busy, done, wgt_load, ifm_load, sa_start, wb_start;
  logic [18:0] ofm_base_addr;
  logic [6:0] tile_idx;
  int cyc = 0, n_vec = 0, n_err = 0;
  int wgt_lat = 1, ifm_pre = 1, ifm_hold = 3, sa_lat = 1, wb_lat = 1;
  bit spur = 0, pend = 0;
  logic prev_v;
  int wgt_c = 0, ifm_c = 0, sa_c = 0, wb_c = 0;
  int wgt_n, ifm_n, sa_n, wb_n, done_n;
  int start_cyc, wgtd_cyc, fall_cyc, sad_cyc, wbd_cyc, exp_sa;
  conv_tile_scheduler dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .wgt_load(wgt_load), .wgt_done(wgt_done), .ifm_load(ifm_load),
    .ifm_addr_valid(ifm_addr_valid), .sa_start(sa_start), .sa_done(sa_done),
    .wb_start(wb_start), .wb_done(wb_done), .ofm_base_addr(ofm_base_addr),
    .tile_idx(tile_idx)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic clear_counts();
    wgt_n = 0; ifm_n = 0; sa_n = 0; wb_n = 0; done_n = 0; pend = 0;
    wgtd_cyc = -1000; fall_cyc = -1000; sad_cyc = -1000; wbd_cyc = -1000;
  endtask
  task automatic kick();
    clear_counts();
    @(posedge clk); #2 start = 1'b1; start_cyc = cyc;
    @(posedge clk); #2 start = 1'b0;
  endtask
  task automatic run_layer(input bit inject);
    kick();
    if (inject) begin
      repeat (30) @(posedge clk);
      #2 start = 1'b1;
      @(posedge clk); #2 start = 1'b0;
    end
    for (int i = 0; i < 20000 && done_n == 0; i++) @(posedge clk);
    chk("layer_done", done_n, 1);
    repeat (3) @(posedge clk);
    #2;
    chk("wgt_count", wgt_n, 1);
    chk("ifm_count", ifm_n, 64);
    chk("sa_count", sa_n, 64);
    chk("wb_count", wb_n, 64);
    chk("done_count", done_n, 1);
    chk("busy_idle", busy, 0);
  endtask
  // monitor samples DUT outputs first, then the responders update inputs
  initial forever begin
    @(negedge clk);
    if (wgt_load) begin wgt_n++; chk("start2wgt", cyc - start_cyc, 1); end
    if (ifm_load) begin ifm_n++; if (ifm_n == 1) chk("wgt2ifm", cyc - wgtd_cyc, 1); end
    if (sa_start) begin
      chk("tile_idx", tile_idx, sa_n);
      chk("busy_run", busy, 1);
      exp_sa = (fall_cyc + 2 > wbd_cyc + 1) ? fall_cyc + 2 : wbd_cyc + 1;
      chk("sa_time", cyc, exp_sa);
      sa_n++;
    end
    if (wb_start) begin
      chk("wb_while_pend", pend, 0);
      chk("ofm_base", ofm_base_addr, wb_n * 16);
      chk("sa2wb", cyc - sad_cyc, 1);
      wb_n++;
      pend = 1;
    end
    if (done) begin
      done_n++;
      chk("wb2done", cyc - wbd_cyc, 2);
      chk("busy_at_done", busy, 0);
    end
    wgt_done = 1'b0; sa_done = 1'b0; wb_done = 1'b0;
    if (!rst_n) begin
      wgt_c = 0; ifm_c = 0; sa_c = 0; wb_c = 0; ifm_addr_valid = 1'b0; pend = 0;
    end else begin
      if (wgt_c > 0) begin wgt_c--; if (wgt_c == 0) begin wgt_done = 1'b1; wgtd_cyc = cyc; end end
      if (wgt_load) wgt_c = wgt_lat;
      if (ifm_c > 0) begin
        ifm_c--;
        prev_v = ifm_addr_valid;
        ifm_addr_valid = ifm_c > 0 && ifm_c <= ifm_hold;
        if (prev_v && !ifm_addr_valid) fall_cyc = cyc;
        if (spur && ifm_addr_valid && ifm_c == ifm_hold / 2) sa_done = 1'b1;
      end
      if (ifm_load) ifm_c = ifm_pre + ifm_hold;
      if (sa_c > 0) begin sa_c--; if (sa_c == 0) begin sa_done = 1'b1; sad_cyc = cyc; end end
      if (sa_start) sa_c = sa_lat;
      if (wb_c > 0) begin wb_c--; if (wb_c == 0) begin wb_done = 1'b1; wbd_cyc = cyc; pend = 0; end end
      if (wb_start) wb_c = wb_lat;
    end
  end
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_pulses", {done, wgt_load, ifm_load, sa_start, wb_start}, 0);
    chk("rst_tile", tile_idx, 0);
    chk("rst_base", ofm_base_addr, 0);
    @(posedge clk); #2 rst_n = 1'b1;
    run_layer(0);
    ifm_pre = 1; ifm_hold = 27; sa_lat = 40; wb_lat = 100; wgt_lat = 5;
    run_layer(0);
    ifm_pre = 3; ifm_hold = 27; sa_lat = 40; wb_lat = 31; wgt_lat = 2; spur = 1;
    run_layer(1);
    spur = 0; ifm_pre = 1; ifm_hold = 4; sa_lat = 40; wb_lat = 3;
    kick();
    for (int i = 0; i < 5000 && sa_n < 11; i++) @(posedge clk);
    chk("reach_tile10", sa_n, 11);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_pulses", {done, wgt_load, ifm_load, sa_start, wb_start}, 0);
    chk("mid_rst_tile", tile_idx, 0);
    chk("mid_rst_base", ofm_base_addr, 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    clear_counts();
    repeat (20) @(posedge clk);
    #2;
    chk("quiet_after_rst", wgt_n + ifm_n + sa_n + wb_n + done_n, 0);
    chk("quiet_busy", busy, 0);
    run_layer(0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
